// File: rtl/y86_execute_alu.sv
// Y86-64 execute stage: operand selection, 64-bit ALU producing valE combinationally,
// and the ZF/SF/OF condition-code registers that only OPq instructions update.
module y86_execute_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic [1:0]  aluFun,
  input  logic [63:0] valC,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  output logic [63:0] valE,
  output logic        ZF,
  output logic        SF,
  output logic        OF
);

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] F_ADD = 2'd0;
  localparam logic [1:0] F_SUB = 2'd1;
  localparam logic [1:0] F_AND = 2'd2;

  logic [63:0] w_alu_a;
  logic [63:0] w_alu_b;
  logic [63:0] w_result;
  logic        w_zf_next;
  logic        w_sf_next;
  logic        w_of_next;
  logic        r_zf;
  logic        r_sf;
  logic        r_of;

  // Stack ops move rsp by one 8-byte word; call/push grow the stack downward.
  always_comb begin
    w_alu_a = 64'd0;
    unique case (icode)
      I_RRMOVQ, I_OPQ:            w_alu_a = valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alu_a = valC;
      I_CALL, I_PUSHQ:            w_alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:              w_alu_a = 64'd8;
      default:                    w_alu_a = 64'd0;
    endcase
  end

  always_comb begin
    w_alu_b = 64'd0;
    unique case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: w_alu_b = valB;
      default:                                                   w_alu_b = 64'd0;
    endcase
  end

  always_comb begin
    w_result  = 64'd0;
    w_of_next = 1'b0;
    unique case (aluFun)
      F_ADD: begin
        w_result  = w_alu_b + w_alu_a;
        w_of_next = (w_alu_a[63] == w_alu_b[63]) && (w_result[63] != w_alu_a[63]);
      end
      F_SUB: begin
        w_result  = w_alu_b - w_alu_a;
        w_of_next = (w_alu_a[63] != w_alu_b[63]) && (w_result[63] != w_alu_b[63]);
      end
      F_AND: w_result = w_alu_b & w_alu_a;
      default: w_result = w_alu_b ^ w_alu_a;
    endcase
    w_zf_next = (w_result == 64'd0);
    w_sf_next = w_result[63];
  end

  // Reset state ZF=1 matches the architectural power-on condition codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (icode == I_OPQ) begin
      r_zf <= w_zf_next;
      r_sf <= w_sf_next;
      r_of <= w_of_next;
    end
  end

  assign valE = w_result;
  assign ZF   = r_zf;
  assign SF   = r_sf;
  assign OF   = r_of;

endmodule

// File: tb/tb_y86_execute_alu.sv
// Bench for y86_execute_alu: directed vector table with cumulative flag expectations,
// then randomized instructions checked against a behavioural model.
module tb_y86_execute_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode;
  logic [1:0]  aluFun;
  logic [63:0] valC;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valE;
  logic        ZF;
  logic        SF;
  logic        OF;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  y86_execute_alu dut (
    .clk(clk), .rst(rst), .icode(icode), .aluFun(aluFun),
    .valC(valC), .valA(valA), .valB(valB),
    .valE(valE), .ZF(ZF), .SF(SF), .OF(OF)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  icode;
    logic [1:0]  fun;
    logic [63:0] c;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_e;
    logic [2:0]  exp_flags;  // {ZF,SF,OF} after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic [3:0] ic, logic [1:0] f,
                              logic [63:0] c, logic [63:0] a, logic [63:0] b,
                              logic [63:0] e, logic [2:0] fl);
    vec_t v;
    v.name = n; v.rst = r; v.icode = ic; v.fun = f; v.c = c; v.a = a; v.b = b;
    v.exp_e = e; v.exp_flags = fl;
    return v;
  endfunction

  // Reference model: operands from the instruction semantics, overflow from exact signed arithmetic.
  function automatic logic [63:0] model_a(logic [3:0] ic, logic [63:0] c, logic [63:0] a);
    case (ic)
      4'h2, 4'h6:       return a;
      4'h3, 4'h4, 4'h5: return c;
      4'h8, 4'hA:       return 64'd0 - 64'd8;
      4'h9, 4'hB:       return 64'd8;
      default:          return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] model_b(logic [3:0] ic, logic [63:0] b);
    if (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) return b;
    return 64'd0;
  endfunction

  function automatic logic [63:0] model_e(logic [3:0] ic, logic [1:0] f, logic [63:0] c,
                                          logic [63:0] a, logic [63:0] b);
    logic [63:0] x, y;
    x = model_a(ic, c, a);
    y = model_b(ic, b);
    case (f)
      2'd0:    return y + x;
      2'd1:    return y - x;
      2'd2:    return y & x;
      default: return y ^ x;
    endcase
  endfunction

  function automatic logic [2:0] model_flags(logic [1:0] f, logic [63:0] a, logic [63:0] b,
                                             logic [63:0] r);
    logic signed [65:0] exact;
    logic signed [65:0] wrapped;
    logic ovf;
    ovf = 1'b0;
    wrapped = $signed({{2{r[63]}}, r});
    if (f == 2'd0) begin
      exact = $signed({{2{b[63]}}, b}) + $signed({{2{a[63]}}, a});
      ovf = (exact != wrapped);
    end else if (f == 2'd1) begin
      exact = $signed({{2{b[63]}}, b}) - $signed({{2{a[63]}}, a});
      ovf = (exact != wrapped);
    end
    return {(r == 64'd0), r[63], ovf};
  endfunction

  task automatic check_e(string n, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s valE got=%h want=%h", n, got, want);
    end
  endtask

  task automatic check_f(string n, logic [2:0] got, logic [2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s flags{Z,S,O} got=%b want=%b", n, got, want);
    end
  endtask

  // Called just after a rising edge: drive, check valE mid-cycle, clock, check flags.
  task automatic run_vec(vec_t v);
    rst = v.rst; icode = v.icode; aluFun = v.fun; valC = v.c; valA = v.a; valB = v.b;
    #2;
    check_e(v.name, valE, v.exp_e);
    @(posedge clk);
    #1;
    check_f(v.name, {ZF, SF, OF}, v.exp_flags);
    $display("vec %-10s rst=%0b icode=%h fun=%0d valE=%h flags=%b", v.name, v.rst, v.icode,
             v.fun, valE, {ZF, SF, OF});
  endtask

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [2:0]  m_flags;
    logic [63:0] m_e;
    logic [63:0] pick[6];

    rst = 1'b1; icode = 4'h0; aluFun = 2'd0; valC = '0; valA = '0; valB = '0;
    @(posedge clk);
    #1;

    vecs.push_back(mk("reset",   1, 4'h6, 0, 0, 5, 7, 64'd12, 3'b100));
    vecs.push_back(mk("sub_eq",  0, 4'h6, 1, 0, 5, 5, 64'd0,  3'b100));
    vecs.push_back(mk("sub_neg", 0, 4'h6, 1, 0, 6, 5, ONES,   3'b010));
    vecs.push_back(mk("add_ovf", 0, 4'h6, 0, 0, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, 3'b011));
    vecs.push_back(mk("sub_ovf", 0, 4'h6, 1, 0, 1, MINN, MAXP, 3'b001));
    vecs.push_back(mk("and",     0, 4'h6, 2, 0, 64'hF0, 64'h3C, 64'h30, 3'b000));
    vecs.push_back(mk("xor",     0, 4'h6, 3, 0, 64'hF0, 64'h3C, 64'hCC, 3'b000));
    vecs.push_back(mk("irmovq",  0, 4'h3, 0, 100, 20, 1000, 64'd100,  3'b000));
    vecs.push_back(mk("rmmovq",  0, 4'h4, 0, 100, 20, 1000, 64'd1100, 3'b000));
    vecs.push_back(mk("mrmovq",  0, 4'h5, 0, 100, 20, 1000, 64'd1100, 3'b000));
    vecs.push_back(mk("rrmovq",  0, 4'h2, 0, 100, 20, 1000, 64'd20,   3'b000));
    vecs.push_back(mk("pushq",   0, 4'hA, 0, 100, 20, 1000, 64'd992,  3'b000));
    vecs.push_back(mk("popq",    0, 4'hB, 0, 100, 20, 1000, 64'd1008, 3'b000));
    vecs.push_back(mk("call",    0, 4'h8, 0, 100, 20, 1000, 64'd992,  3'b000));
    vecs.push_back(mk("ret",     0, 4'h9, 0, 100, 20, 1000, 64'd1008, 3'b000));
    vecs.push_back(mk("halt",    0, 4'h0, 0, 100, 20, 1000, 64'd0,    3'b000));
    vecs.push_back(mk("undef_c", 0, 4'hC, 1, 100, 20, 1000, 64'd0,    3'b000));
    vecs.push_back(mk("undef_f", 0, 4'hF, 3, 100, 20, 1000, 64'd0,    3'b000));
    // Flag hold: ZF set by OPq must survive non-OPq instructions with a zero result.
    vecs.push_back(mk("set_zf",  0, 4'h6, 1, 0, 9, 9, 64'd0, 3'b100));
    vecs.push_back(mk("hold1",   0, 4'h3, 0, 0, 3, 4, 64'd0, 3'b100));
    vecs.push_back(mk("hold2",   0, 4'h3, 0, 0, 3, 4, 64'd0, 3'b100));
    vecs.push_back(mk("hold3",   0, 4'h3, 1, 0, ONES, 4, 64'd0, 3'b100));
    vecs.push_back(mk("clr_zf",  0, 4'h6, 0, 0, 1, 1, 64'd2, 3'b000));
    vecs.push_back(mk("set_sf",  0, 4'h6, 1, 0, 6, 5, ONES, 3'b010));
    // Reset wins over an OPq that would otherwise set SF.
    vecs.push_back(mk("rst_prio", 1, 4'h6, 1, 0, 6, 5, ONES, 3'b100));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Randomized phase; model flags continue from the last directed state.
    m_flags = 3'b100;
    pick[0] = 64'd0; pick[1] = 64'd1; pick[2] = MAXP; pick[3] = MINN; pick[4] = ONES;
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      pick[5] = {$urandom, $urandom};
      v.name  = $sformatf("rnd%0d", n);
      v.rst   = ($urandom_range(0, 24) == 0);
      v.icode = ($urandom_range(0, 1) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      v.fun   = 2'($urandom_range(0, 3));
      v.c     = {$urandom, $urandom};
      v.a     = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 5)] : {$urandom, $urandom};
      v.b     = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 5)] : {$urandom, $urandom};
      m_e     = model_e(v.icode, v.fun, v.c, v.a, v.b);
      if (v.rst)
        m_flags = 3'b100;
      else if (v.icode == 4'h6)
        m_flags = model_flags(v.fun, v.a, v.b, m_e);
      v.exp_e = m_e;
      v.exp_flags = m_flags;
      run_vec(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y86_execute_alu.md
Name: y86_execute_alu

Overview:
- Execute stage of the single-cycle Y86-64 processor.
- Selects the two ALU operands from icode, valC, valA and valB, then computes valE combinationally.
- Holds the three condition-code flags (ZF, SF, OF) in registers; the flags are updated only by OPq instructions.
- Sits between the register file / instruction decode and the condition-evaluation and memory-address logic.

Parameters:
- None. Data width is fixed at 64 bits.

Ports:
- clk  input  1  system clock; flags update on the rising edge
- rst  input  1  synchronous, active-high reset
- icode  input  4  instruction code of the current instruction
- aluFun  input  2  ALU operation: 0 add, 1 sub, 2 and, 3 xor
- valC  input  64  instruction constant or displacement
- valA  input  64  register value read via rA (or rsp for ret/popq)
- valB  input  64  register value read via rB (or rsp for stack ops)
- valE  output  64  ALU result, combinational
- ZF  output  1  registered zero flag
- SF  output  1  registered sign flag
- OF  output  1  registered signed-overflow flag

Behaviour:
- The icode encoding follows the Y86-64 ISA, as used in the rules below.
- aluA selection:
  - icode 2 (rrmovq/cmovXX) or 6 (OPq): valA
  - icode 3 (irmovq), 4 (rmmovq) or 5 (mrmovq): valC
  - icode 8 (call) or A (pushq): -8 (64'hFFFF_FFFF_FFFF_FFF8)
  - icode 9 (ret) or B (popq): +8
  - all other icodes: 0
- aluB selection:
  - icode 4, 5, 6, 8, 9, A, B: valB
  - all other icodes (including 2 and 3): 0
- valE is combinational, zero-cycle latency, with all 64-bit arithmetic wrapping modulo 2^64:
  - aluFun 0: aluB + aluA
  - aluFun 1: aluB − aluA
  - aluFun 2: aluB & aluA
  - aluFun 3: aluB ^ aluA
- valE depends only on the current inputs. Flags never feed back into valE.
- Next-flag values, computed from the current result r:
  - ZF = (r == 0)
  - SF = r[63]
  - OF for add: aluA[63] == aluB[63] and r[63] != aluA[63]
  - OF for sub: aluA[63] != aluB[63] and r[63] != aluB[63]
  - OF for and/xor: 0
- Flag registers:
  - load the next-flag values on the rising clk edge only when icode == 6 and rst == 0
  - hold their value for every other icode
- Consequence: a cmov or jXX in the cycle after an OPq sees that OPq's flags.
- Reset:
  - when rst = 1 at a rising edge: ZF <= 1, SF <= 0, OF <= 0 (Y86-64 architectural reset state)
  - reset takes priority over an OPq update in the same cycle
  - valE is unaffected by reset because it is combinational
- Undefined icodes (C–F) are treated like halt/nop:
  - operands are 0, so valE = 0 for add/sub/and/xor
  - flags are held
- No handshakes and no internal state beyond the three flag flops.

Test Plan:
- Reset: assert rst for one edge with icode=6, aluFun=0, valA=5, valB=7 → after the edge ZF=1, SF=0, OF=0; valE=12 combinationally throughout.
- OPq subq: icode=6, aluFun=1, valA=5, valB=5, then a clock edge → valE=0; ZF=1, SF=0, OF=0. Then valA=6, valB=5, edge → valE=-1 (all ones); ZF=0, SF=1, OF=0.
- Overflow:
  - addq: icode=6, aluFun=0, valA=valB=64'h7FFF_FFFF_FFFF_FFFF → valE=64'hFFFF_FFFF_FFFF_FFFE; after the edge SF=1, OF=1.
  - subq: valB=64'h8000_0000_0000_0000, valA=1 → valE=64'h7FFF_FFFF_FFFF_FFFF, OF=1, SF=0.
- Logic ops: icode=6, aluFun=2, valA=0xF0, valB=0x3C → valE=0x30, OF=0. With aluFun=3 → valE=0xCC.
- Operand muxing with aluFun=0, valC=100, valA=20, valB=1000:
  - icode=3 → 100
  - icode=4 → 1100
  - icode=2 → 20
  - icode=A → 992
  - icode=B → 1008
  - icode=8 → 992
  - icode=9 → 1008
  - icode=0 → 0
- Flag hold: after an OPq leaves ZF=1, clock icode=3 with valC=0 for several edges → flags unchanged. A following OPq with a nonzero result clears ZF.
